// File: rtl/serial_read_buffer.sv
// rtl/serial_read_buffer.sv - serial-to-parallel receive buffer sampling on read strobes
module serial_read_buffer #(
    parameter int BUF_SIZE  = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                start,
    input  logic                read_sig,
    input  logic                data_in,
    output logic [BUF_SIZE-1:0] data_out,
    output logic                busy,
    output logic                done
);

    localparam int CW = $clog2(BUF_SIZE + 1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [BUF_SIZE-1:0] shreg_q, shreg_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BUF_SIZE-1:0] data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [BUF_SIZE-1:0] shifted;

    // Shift direction decides whether the first bit ends up as MSB or LSB
    always_comb begin
        shifted = '0;
        if (LSB_FIRST) begin
            shifted = {data_in, shreg_q[BUF_SIZE-1:1]};
        end else begin
            shifted = {shreg_q[BUF_SIZE-2:0], data_in};
        end
    end

    // Next-state and registered-output logic; done is a one-cycle pulse
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // Strobes while idle are dropped, even one coincident with start
                busy_d = 1'b0;
                if (start) begin
                    state_d = READ;
                    cnt_d   = '0;
                    shreg_d = '0;
                    busy_d  = 1'b1;
                end
            end
            READ: begin
                // A repeated start is ignored so an armed word cannot be restarted
                if (read_sig) begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(BUF_SIZE - 1)) begin
                        data_d  = shifted;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any partial word
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_out = data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/serial_read_buffer.md
Name: serial_read_buffer

Overview:
Serial-to-parallel receive buffer; the counterpart of the serial write buffer. After a start pulse it samples one bit of a serial line on each synchronous read strobe, typically an edge-detector pulse derived from the bus clock. After BUF_SIZE bits it presents the assembled word and pulses done. It sits between the edge-detected bus-clock/data pins and the MITM control logic that inspects or modifies intercepted bytes.

Parameters:
BUF_SIZE, 8, number of bits per word; legal range BUF_SIZE >= 2.
LSB_FIRST, 0, 0 = first received bit lands in data_out[BUF_SIZE-1] (MSB first); 1 = first received bit lands in data_out[0].

Ports:
sys_clk  input  1  system clock; all logic on its rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  single-cycle pulse that arms reception of one word.
read_sig  input  1  single-cycle sample strobe, synchronous to sys_clk.
data_in  input  1  serial data bit; sampled in the sys_clk cycle where read_sig=1.
data_out  output  BUF_SIZE  last completed word.
busy  output  1  high while a word is being received.
done  output  1  one-cycle pulse when data_out has been updated with a new word.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; data_out=0, busy=0, done=0; shift register and bit counter cleared. Applies immediately, including mid-word. The partial word is discarded and no done pulse is produced.
- Internal state: shift register [BUF_SIZE-1:0]; bit counter of width $clog2(BUF_SIZE+1); FSM with states IDLE and READ. All outputs are registered.
- IDLE:
  - busy=0.
  - start=1: next state READ, counter=0, shift register=0; busy=1 from the next cycle.
  - read_sig in IDLE is ignored, including a read_sig coincident with start. The first sample is taken on the first read_sig in the cycle after start.
- READ:
  - On each cycle with read_sig=1, data_in is shifted in and the counter increments.
  - LSB_FIRST=0: shreg <= {shreg[BUF_SIZE-2:0], data_in}.
  - LSB_FIRST=1: shreg <= {data_in, shreg[BUF_SIZE-1:1]}.
  - Cycles without read_sig hold all state. There is no timeout.
  - start=1 while in READ is ignored; reception is not restarted.
- Completion: on the read_sig that delivers bit number BUF_SIZE (counter == BUF_SIZE-1 before the increment), the next cycle shows:
  - data_out = completed word, including the final bit;
  - done=1 for exactly one cycle;
  - busy=0;
  - state=IDLE.
  - Latency: done rises one sys_clk cycle after the final read_sig cycle.
- data_out holds its value until the next completion or a reset. It is not disturbed by partial words.
- Back-to-back operation: start asserted in the done cycle is accepted (state is IDLE). busy is high again the following cycle.
- busy and done are never high in the same cycle.

Test Plan:
- Reset: drive rst=0 for 1 ns at t=10 ns with no stimulus -> data_out=0, busy=0, done=0 immediately and thereafter.
- MSB-first word: LSB_FIRST=0, start pulse, then 8 read_sig pulses (8 sys_clk apart) with data_in = 1,0,0,1,1,1,0,0 -> busy=1 during reception; one cycle after the 8th strobe data_out=8'h9C, done=1 for one cycle, busy=0.
- Back-to-back: assert start in the done cycle of the 0x9C word, then feed bits 1,1,1,0,0,1,0,0 -> busy=1 the next cycle; data_out stays 8'h9C until completion, then becomes 8'hE4 with a single done pulse.
- Reset mid-word: start, 3 strobes, then rst=0 for 1 ns -> busy=0, data_out=0, no done pulse. A subsequent start plus 8 bits of 0xE4 yields data_out=8'hE4.
- Ignored events:
  - 5 read_sig pulses while IDLE -> data_out unchanged, no done pulse.
  - start re-pulsed after the 4th bit of a 0x9C word -> word still completes as 8'h9C after 8 total strobes.
- LSB_FIRST=1: serial bits 1,0,0,1,1,1,0,0 -> data_out=8'h39, one done pulse.
